// File: rtl/nn_rgb_pkg.sv
// Types and default frame geometry shared by the nn_rgb capture path
// (pixel address generator and the downstream delay-alignment stage).
package nn_rgb_pkg;

    localparam int DEF_H_ACTIVE = 320;
    localparam int DEF_V_ACTIVE = 240;
    localparam int DEF_ADDR_W   = 17;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_ACTIVE
    } pix_state_e;

endpackage

// File: rtl/edge_det.sv
// Registered rise/fall detector: edges are reported in the cycle the input
// differs from its one-cycle registered copy.
module edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic sig_q;
    logic sig_d;

    assign sig_d = sig_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign rise_o = sig_i & ~sig_q;
    assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/pixel_addr_gen.sv
// Frame-buffer write-address generator: tracks vsync/href framing and turns
// accepted pixels into registered (addr_o, we_o) writes, one line per row_base.
module pixel_addr_gen
    import nn_rgb_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vsync_i,
    input  logic              href_i,
    input  logic              pix_valid_i,
    output logic              vsync_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              we_o,
    output logic              frame_done_o,
    output logic              short_line_o
);

    localparam int XW = $clog2(H_ACTIVE + 1);
    localparam int YW = $clog2(V_ACTIVE + 1);
    localparam logic [XW-1:0]     X_LIM    = XW'(H_ACTIVE);
    localparam logic [YW-1:0]     Y_LIM    = YW'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_ACTIVE);

    pix_state_e        state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] addr_o_q, addr_o_d;
    logic              we_q, we_d;
    logic              frame_done_q, frame_done_d;
    logic              short_line_q, short_line_d;
    logic              vsync_q, vsync_d;
    logic              accept;

    logic vsync_rise, vsync_fall;
    logic href_rise_unused, href_fall;

    edge_det u_vsync_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (vsync_i),
        .rise_o (vsync_rise),
        .fall_o (vsync_fall)
    );

    edge_det u_href_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (href_i),
        .rise_o (href_rise_unused),
        .fall_o (href_fall)
    );

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        row_base_d   = row_base_q;
        addr_d       = addr_q;
        addr_o_d     = addr_o_q;
        we_d         = 1'b0;
        frame_done_d = 1'b0;
        short_line_d = 1'b0;
        vsync_d      = vsync_i;
        accept       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (vsync_rise) state_d = ST_SYNC;
            end
            ST_SYNC: begin
                if (vsync_fall) begin
                    state_d    = ST_ACTIVE;
                    x_d        = '0;
                    y_d        = '0;
                    row_base_d = '0;
                    addr_d     = '0;
                end
            end
            ST_ACTIVE: begin
                accept = pix_valid_i && href_i && (x_q < X_LIM) && (y_q < Y_LIM);
                if (accept) begin
                    we_d     = 1'b1;
                    addr_o_d = addr_q;
                    addr_d   = addr_q + ADDR_W'(1);
                    x_d      = x_q + XW'(1);
                end
                // The line advance looks at x after this cycle's pixel, so a last pixel counts.
                if (href_fall && (x_d != '0)) begin
                    short_line_d = (x_d < X_LIM) && (y_q < Y_LIM);
                    y_d          = y_q + YW'(1);
                    x_d          = '0;
                    row_base_d   = row_base_q + ROW_STEP;
                    addr_d       = row_base_q + ROW_STEP;
                end
                if (vsync_rise) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_SYNC;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            row_base_q   <= '0;
            addr_q       <= '0;
            addr_o_q     <= '0;
            we_q         <= 1'b0;
            frame_done_q <= 1'b0;
            short_line_q <= 1'b0;
            vsync_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            row_base_q   <= row_base_d;
            addr_q       <= addr_d;
            addr_o_q     <= addr_o_d;
            we_q         <= we_d;
            frame_done_q <= frame_done_d;
            short_line_q <= short_line_d;
            vsync_q      <= vsync_d;
        end
    end

    assign vsync_o      = vsync_q;
    assign addr_o       = addr_o_q;
    assign we_o         = we_q;
    assign frame_done_o = frame_done_q;
    assign short_line_o = short_line_q;

endmodule

// File: doc/pixel_addr_gen.md
PIXEL_ADDR_GEN -- requirements
Module: pixel_addr_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 320, pixels per stored line.
REQ-002 SHALL have parameter V_ACTIVE, default 240, lines per stored frame.
REQ-003 SHALL have parameter ADDR_W, default 17, frame-buffer address width; H_ACTIVE*V_ACTIVE SHALL fit in ADDR_W bits.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port vsync_i, input, 1, frame sync from the pixel source, high between frames, synchronous to clk.
REQ-007 SHALL have port href_i, input, 1, line-active qualifier, synchronous to clk.
REQ-008 SHALL have port pix_valid_i, input, 1, one pixel present this cycle.
REQ-009 SHALL have port vsync_o, output, 1, vsync_i registered once; feeds the delay-alignment stage.
REQ-010 SHALL have port addr_o, output, ADDR_W, frame-buffer write address.
REQ-011 SHALL have port we_o, output, 1, write enable qualifying addr_o.
REQ-012 SHALL have port frame_done_o, output, 1, one-cycle pulse at the end of a synced frame.
REQ-013 SHALL have port short_line_o, output, 1, one-cycle pulse when a line ends with fewer than H_ACTIVE pixels.

Function
REQ-014 All outputs SHALL be registered; accepted pixel at cycle N yields we_o=1 with its addr_o at cycle N+1.
REQ-015 Edges of vsync_i and href_i SHALL be detected against a one-cycle registered copy of each.
REQ-016 FSM states: IDLE, SYNC, ACTIVE.
REQ-017 IDLE: no writes; on vsync_i rising edge -> SYNC. A frame already in progress at reset SHALL be discarded.
REQ-018 SYNC: no writes; on vsync_i falling edge -> ACTIVE, with x=0, y=0, row_base=0 and addr=0.
REQ-019 ACTIVE: a pixel is accepted when pix_valid_i=1, href_i=1, x<H_ACTIVE and y<V_ACTIVE; on acceptance we_o=1, addr_o=addr, then addr+1 and x+1.
REQ-020 Pixels with x>=H_ACTIVE or y>=V_ACTIVE SHALL be dropped (we_o=0) with no counter change except x saturating at H_ACTIVE.
REQ-021 On href_i falling edge in ACTIVE with x>0: y+1, x=0, row_base+H_ACTIVE, addr set to the new row_base.
REQ-022 On that edge with 0<x<H_ACTIVE and y<V_ACTIVE, short_line_o SHALL pulse for one cycle; skipped addresses SHALL NOT be written.
REQ-023 An href_i falling edge with x=0 SHALL NOT advance y.
REQ-024 On vsync_i rising edge in ACTIVE: frame_done_o pulses one cycle -> SYNC. A pixel accepted in the same cycle SHALL still be written.
REQ-025 Pixel acceptance and href_i falling in the same cycle SHALL write the pixel first, then apply the line advance.
REQ-026 addr_o SHALL never exceed H_ACTIVE*V_ACTIVE-1 while we_o=1.
REQ-027 addr_o SHALL hold its last value when we_o=0.

Reset
REQ-028 rst_n low SHALL asynchronously force: state=IDLE; x, y, row_base, addr=0; addr_o=0; we_o, vsync_o, frame_done_o, short_line_o=0; edge registers=0.
REQ-029 Reset asserted mid-line SHALL abort the frame; after release no write occurs until a full vsync_i high-then-low sequence.

Structure
REQ-030 The FSM state enum and default H_ACTIVE/V_ACTIVE/ADDR_W constants SHALL live in the shared nn_rgb package, also used by the downstream delay stage.
REQ-031 One sub-module, edge_det (registered rise/fall detection), SHALL be instantiated for vsync_i and href_i; all other logic stays flat.

Verification
REQ-032 Reset, vsync 1->0, 240 lines of 320 valid pixels, then vsync rising -> addresses 0..76799 written once each in order; frame_done_o pulses once.
REQ-033 Line 0 has 100 pixels -> short_line_o pulses once; line 1 starts at addr 320; addresses 100..319 are never written.
REQ-034 Line of 330 valid pixels -> only 320 writes (addr 0..319); next line starts at 320.
REQ-035 Pixels before the first vsync after reset -> we_o stays 0; writing begins at addr 0 only after a vsync high-low sequence.
REQ-036 rst_n pulsed low at line 5 pixel 10 -> all outputs 0 immediately; the next frame restarts at addr 0.
REQ-037 Pixel accepted in the same cycle href falls at x=319 -> written at row_base+319; the next line starts at row_base+320; short_line_o stays 0.
